// File: rtl/sa_ws_feeder_if.sv
// Upstream beat handshake plus skewed array-facing outputs of the weight-stationary feeder.
// master = upstream source / bench side, slave = feeder side.
interface sa_ws_feeder_if #(
    parameter int SA_ROW     = 3,
    parameter int DATA_WIDTH = 8
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [SA_ROW-1:0][DATA_WIDTH-1:0]    in_data;
    logic                                 sa_iv;
    logic [SA_ROW-1:0][DATA_WIDTH-1:0]    row_A_o;
    logic                                 busy;
    logic                                 done;

    modport master (
        output in_valid, in_data,
        input  in_ready, sa_iv, row_A_o, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, sa_iv, row_A_o, busy, done
    );
endinterface

// File: rtl/sa_ws_feeder.sv
// Buffers one burst of ifmap columns, then streams it diagonally skewed into a systolic array.
// Stream lasts VECTOR_LENGTH+SA_ROW+SA_COL-1 cycles; in_ready is low while streaming and for one GAP cycle.
module sa_ws_feeder #(
    parameter int SA_ROW        = 3,
    parameter int SA_COL        = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_LENGTH = 8
) (
    input  logic            clk,
    input  logic            nrst,
    sa_ws_feeder_if.slave   bus
);
    localparam int LATENCY = VECTOR_LENGTH + SA_ROW + SA_COL - 1;
    localparam int TW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int KW      = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(LATENCY - 1);
    localparam logic [KW-1:0] K_LAST = KW'(VECTOR_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, GAP} state_t;

    state_t                              state;
    logic [KW-1:0]                       k;
    logic [TW-1:0]                       t;
    logic [SA_ROW-1:0][DATA_WIDTH-1:0]   burst_buf [VECTOR_LENGTH];
    logic [SA_ROW-1:0][DATA_WIDTH-1:0]   row_a;
    logic                                accept;

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            k     <= '0;
            t     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (VECTOR_LENGTH == 1) begin
                            state <= STREAM;
                            t     <= '0;
                        end else begin
                            state <= LOAD;
                            k     <= KW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (k == K_LAST) begin
                            state <= STREAM;
                            k     <= '0;
                            t     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (t == T_LAST) begin
                        state <= GAP;
                        t     <= '0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer has no reset: contents are only observable after a full load overwrites them.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < VECTOR_LENGTH; j++) begin
                if (int'(k) == j) burst_buf[j] <= bus.in_data;
            end
        end
    end

    // Row r sees beat t-r; outside the burst window the row is zero-padded.
    always_comb begin
        row_a = '0;
        if (state == STREAM) begin
            for (int r = 0; r < SA_ROW; r++) begin
                for (int j = 0; j < VECTOR_LENGTH; j++) begin
                    if (int'(t) == j + r) row_a[r] = burst_buf[j][r];
                end
            end
        end
    end

    assign bus.in_ready = (state == IDLE) || (state == LOAD);
    assign bus.sa_iv    = (state == STREAM);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == GAP);
    assign bus.row_A_o  = row_a;
endmodule
